// File: rtl/sysarr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sysarr_pkg
//  Description : Shared systolic-array types and constants. Holds the row
//                width and the number of rows, the single-row and packed-vector
//                typedefs, and row pack/unpack helpers. Row 0 always occupies
//                the MSBs of a packed vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package sysarr_pkg;

    localparam int PARTIAL_SUM_BW = 19;
    localparam int MATRIX_SIZE    = 8;
    localparam int VEC_W          = PARTIAL_SUM_BW * MATRIX_SIZE;

    typedef logic signed [PARTIAL_SUM_BW-1:0] psum_t;
    typedef logic        [VEC_W-1:0]          psum_vec_t;

    // Row r of a packed vector; row 0 sits in the MSBs.
    function automatic psum_t get_row(input psum_vec_t v, input int r);
        int sh;
        sh = (MATRIX_SIZE - 1 - r) * PARTIAL_SUM_BW;
        return psum_t'(v >> sh);
    endfunction

    // Returns v with row r replaced by x.
    function automatic psum_vec_t set_row(input psum_vec_t v, input int r, input psum_t x);
        int        sh;
        psum_vec_t mask;
        sh   = (MATRIX_SIZE - 1 - r) * PARTIAL_SUM_BW;
        mask = psum_vec_t'({PARTIAL_SUM_BW{1'b1}}) << sh;
        return (v & ~mask) | (psum_vec_t'($unsigned(x)) << sh);
    endfunction

    // Clamp negative results to zero.
    function automatic psum_t relu(input psum_t x);
        return x[PARTIAL_SUM_BW-1] ? '0 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sysarr_result_collector_if.sv
`default_nettype none
// ============================================================================
//  Interface   : sysarr_result_collector_if
//  Description : Valid/ready vector stream from the result collector to the
//                writeback/controller side.
//                  out_valid - out_data holds a vector (master -> slave)
//                  out_ready - slave accepts when out_valid && out_ready
//                  out_data  - aligned vector, row 0 in MSBs
//  Revision    : 1.0 - initial release
// ============================================================================
interface sysarr_result_collector_if;
    import sysarr_pkg::*;

    logic      out_valid;
    logic      out_ready;
    psum_vec_t out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);

endinterface
`default_nettype wire

// File: rtl/sysarr_vec_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sysarr_vec_fifo
//  Description : Synchronous vector FIFO with a registered head. The count
//                includes the vector presented on rd_data_o, so rd_valid_o is
//                simply (count != 0) registered. A write into an empty FIFO
//                shows up on rd_valid_o the following cycle. A write while
//                full is accepted only if a pop happens in the same cycle.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                wr_en_i       write request, wr_data_i vector to store
//                rd_en_i       consumer ready (pop when rd_valid_o is high)
//                rd_valid_o    head vector valid, rd_data_o head vector
//                count_o       vectors stored (0..DEPTH), full_o count==DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sysarr_vec_fifo
    import sysarr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  psum_vec_t              wr_data_i,
    input  logic                   rd_en_i,
    output logic                   rd_valid_o,
    output psum_vec_t              rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    psum_vec_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          valid_q;
    psum_vec_t     data_q, data_d;
    logic          pop, push;

    assign full_o     = (count_q == FULL_CNT);
    assign count_o    = count_q;
    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;

    always_comb begin
        pop      = rd_en_i && valid_q;
        push     = wr_en_i && (!full_o || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Next head: if the slot being written this cycle becomes the head,
        // take the write data directly since memory is not yet updated.
        data_d = data_q;
        if (count_d != '0) begin
            data_d = (push && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= (count_d != '0);
            data_q   <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sysarr_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : sysarr_result_collector
//  Description : Sink end of the PE row chain. Row r of a result arrives r
//                cycles after row 0; a triangle of delay registers realigns
//                the rows into one vector, which is written into a vector FIFO
//                drained over a valid/ready interface.
//                Latency in_valid -> out_valid is MATRIX_SIZE cycles when idle.
//  Config      : SYSARR_COLLECT_RELU_EN - when defined, negative rows are
//                replaced by zero at the deskew output (no added latency).
//  Ports       : clk, rst       clock, synchronous active-high reset
//                in_valid       row-0 valid (row r implied r cycles later)
//                result_in      skewed row results, row 0 in MSBs
//                out_if         master side of the output vector stream
//                fifo_count     vectors held in the FIFO
//                almost_full    FIFO count plus in-flight vectors >= depth-1
//                overflow       sticky, a vector was dropped on a full FIFO
//                clr_overflow   clears overflow (a same-cycle drop wins)
//  Revision    : 1.0 - initial release
// ============================================================================
module sysarr_result_collector
    import sysarr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  psum_vec_t                    result_in,
    sysarr_result_collector_if.master    out_if,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         almost_full,
    output logic                         overflow,
    input  logic                         clr_overflow
);

    localparam int VP_W  = MATRIX_SIZE - 1;
    localparam int SUM_W = $clog2(FIFO_DEPTH + MATRIX_SIZE) + 1;

    logic [VP_W-1:0]  vpipe_q;
    logic             wr_en;
    logic             fifo_full;
    logic             pop;
    logic             drop;
    logic             overflow_q;
    psum_vec_t        aligned;
    logic [SUM_W-1:0] occupancy;

    // Valid travels alongside row 0; its last stage lines up with the
    // undelayed last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= {vpipe_q[VP_W-2:0], in_valid};
        end
    end

    assign wr_en = vpipe_q[VP_W-1];

    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
        localparam int LO = (MATRIX_SIZE - 1 - r) * PARTIAL_SUM_BW;
        localparam int D  = MATRIX_SIZE - 1 - r;
        psum_t row_in;
        psum_t row_out;

        assign row_in = result_in[LO +: PARTIAL_SUM_BW];

        if (D == 0) begin : g_direct
            assign row_out = row_in;
        end else begin : g_delay
            psum_t dly_q [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    dly_q[0] <= row_in;
                    for (int k = 1; k < D; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end
            assign row_out = dly_q[D-1];
        end

`ifdef SYSARR_COLLECT_RELU_EN
        assign aligned[LO +: PARTIAL_SUM_BW] = relu(row_out);
`else
        assign aligned[LO +: PARTIAL_SUM_BW] = row_out;
`endif
    end

    sysarr_vec_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (aligned),
        .rd_en_i    (out_if.out_ready),
        .rd_valid_o (out_if.out_valid),
        .rd_data_o  (out_if.out_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full)
    );

    assign pop  = out_if.out_valid && out_if.out_ready;
    assign drop = wr_en && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow = overflow_q;

    // Every vector still in the valid pipe will land in the FIFO, so it
    // counts against the free space.
    assign occupancy   = SUM_W'(fifo_count) + SUM_W'($countones(vpipe_q));
    assign almost_full = (occupancy >= SUM_W'(FIFO_DEPTH - 1));

endmodule
`default_nettype wire

// File: tb/tb_sysarr_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysarr_result_collector
//  Description : Directed self-checking bench for sysarr_result_collector.
//                Rows are driven skewed (row r of a vector r cycles after
//                row 0); popped vectors are collected on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sysarr_result_collector;
    import sysarr_pkg::*;

    logic      clk;
    logic      rst;
    logic      in_valid;
    psum_vec_t result_in;
    logic [2:0] fifo_count;
    logic      almost_full;
    logic      overflow;
    logic      clr_overflow;

    sysarr_result_collector_if bus();

    sysarr_result_collector #(
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .result_in    (result_in),
        .out_if       (bus),
        .fifo_count   (fifo_count),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        checks;
    int        errors;
    int        cyc_n;
    logic      hist_v   [MATRIX_SIZE];
    psum_vec_t hist_vec [MATRIX_SIZE];
    psum_vec_t got_q [$];
    int        got_cyc [$];
    psum_vec_t exp_q [$];

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            got_cyc.push_back(cyc_n);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Vector with rows +/-(base+r+1), alternating sign starting positive.
    function automatic psum_vec_t mk_vec(input int base);
        psum_vec_t t = '0;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            t = set_row(t, r, psum_t'((r % 2 == 1) ? -(base + r + 1) : (base + r + 1)));
        end
        return t;
    endfunction

    function automatic psum_vec_t exp_of(input psum_vec_t v);
        psum_vec_t t = v;
`ifdef SYSARR_COLLECT_RELU_EN
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            if (get_row(v, r) < 0) t = set_row(t, r, '0);
        end
`endif
        return t;
    endfunction

    // Advance one cycle, presenting row r of the vector issued r cycles ago.
    task automatic tick(input logic v, input psum_vec_t vec);
        psum_vec_t drv = '0;
        for (int i = MATRIX_SIZE - 1; i > 0; i--) begin
            hist_v[i]   = hist_v[i-1];
            hist_vec[i] = hist_vec[i-1];
        end
        hist_v[0]   = v;
        hist_vec[0] = vec;
        in_valid    = v;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            drv = set_row(drv, r, hist_v[r] ? get_row(hist_vec[r], r) : psum_t'(19'h2AAAA - r));
        end
        result_in = drv;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic clear_queues();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        rst = 1'b0;
        tick(1'b0, '0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
    endtask

    task automatic test_single();
        int        vals [MATRIX_SIZE] = '{1, -2, 3, -4, 5, -6, 7, -8};
`ifdef SYSARR_COLLECT_RELU_EN
        int        evals [MATRIX_SIZE] = '{1, 0, 3, 0, 5, 0, 7, 0};
`else
        int        evals [MATRIX_SIZE] = '{1, -2, 3, -4, 5, -6, 7, -8};
`endif
        psum_vec_t v = '0;
        psum_vec_t e = '0;
        clear_queues();
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            v = set_row(v, r, psum_t'(vals[r]));
            e = set_row(e, r, psum_t'(evals[r]));
        end
        bus.out_ready = 1'b1;
        tick(1'b1, v);
        repeat (6) tick(1'b0, '0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", bus.out_valid); end
        tick(1'b0, '0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== e) begin errors++; $display("FAIL single_data got %h exp %h", bus.out_data, e); end
        tick(1'b0, '0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_stream();
        logic gap = 1'b0;
        clear_queues();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            psum_vec_t v = mk_vec(10 * (i + 1));
            exp_q.push_back(exp_of(v));
            tick(1'b1, v);
        end
        for (int k = 0; k < 100 && got_q.size() < 20; k++) tick(1'b0, '0);
        checks++; if (got_q.size() != 20) begin errors++; $display("FAIL stream_count got %0d exp 20", got_q.size()); end
        for (int i = 0; i < 20 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            if (got_cyc[i] != got_cyc[i-1] + 1) gap = 1'b1;
        end
        checks++; if (gap !== 1'b0) begin errors++; $display("FAIL stream_gap got %b exp 0", gap); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_backpressure();
        logic af_reg = 1'b0;
        int   n = 0;
        clear_queues();
        bus.out_ready = 1'b0;
        // Controller reacts to almost_full one cycle late (registered).
        for (int k = 0; k < 16 && !af_reg; k++) begin
            psum_vec_t v = mk_vec(500 + 10 * n);
            af_reg = almost_full;
            exp_q.push_back(exp_of(v));
            tick(1'b1, v);
            n++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_issued got %0d exp 4", n); end
        repeat (10) tick(1'b0, '0);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b exp 0", overflow); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL bp_almost_full got %b exp 1", almost_full); end
        checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL bp_head_stable got %h exp %h", bus.out_data, exp_q[0]); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && got_q.size() < exp_q.size(); k++) tick(1'b0, '0);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_drain_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        clear_queues();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            psum_vec_t v = mk_vec(1000 + 20 * i);
            if (i < 4) exp_q.push_back(exp_of(v));
            tick(1'b1, v);
        end
        repeat (14) tick(1'b0, '0);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        clr_overflow = 1'b1;
        tick(1'b0, '0);
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        // Drop and clear in the same cycle: the drop must win.
        tick(1'b1, mk_vec(2000));
        repeat (6) tick(1'b0, '0);
        clr_overflow = 1'b1;
        tick(1'b0, '0);
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
        clr_overflow = 1'b1;
        tick(1'b0, '0);
        clr_overflow = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && got_q.size() < 4; k++) tick(1'b0, '0);
        repeat (2) tick(1'b0, '0);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL ovf_drain_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_final got %b exp 0", overflow); end
    endtask

    task automatic test_full_pop();
        psum_vec_t v5 = mk_vec(3000);
        clear_queues();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            psum_vec_t v = mk_vec(2500 + 10 * i);
            exp_q.push_back(exp_of(v));
            tick(1'b1, v);
        end
        repeat (10) tick(1'b0, '0);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fp_filled got %0d exp 4", fifo_count); end
        exp_q.push_back(exp_of(v5));
        tick(1'b1, v5);
        repeat (6) tick(1'b0, '0);
        bus.out_ready = 1'b1;
        tick(1'b0, '0);
        bus.out_ready = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fp_count got %0d exp 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_overflow got %b exp 0", overflow); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL fp_one_pop got %0d exp 1", got_q.size()); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && got_q.size() < 5; k++) tick(1'b0, '0);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL fp_drain_count got %0d exp 5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fp_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        psum_vec_t v = mk_vec(4000);
        clear_queues();
        bus.out_ready = 1'b0;
        tick(1'b1, mk_vec(3500));
        tick(1'b1, mk_vec(3600));
        repeat (9) tick(1'b0, '0);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rm_buffered got %0d exp 2", fifo_count); end
        tick(1'b1, mk_vec(3700));
        tick(1'b1, mk_vec(3800));
        tick(1'b1, mk_vec(3900));
        rst = 1'b1;
        tick(1'b0, '0);
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", fifo_count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rm_almost_full got %b exp 0", almost_full); end
        clear_queues();
        bus.out_ready = 1'b1;
        tick(1'b1, v);
        repeat (6) tick(1'b0, '0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_early got %b exp 0", bus.out_valid); end
        tick(1'b0, '0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rm_latency got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== exp_of(v)) begin errors++; $display("FAIL rm_data got %h exp %h", bus.out_data, exp_of(v)); end
        repeat (3) tick(1'b0, '0);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rm_no_stale got %0d exp 1", got_q.size()); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc_n         = 0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        result_in     = '0;
        clr_overflow  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            hist_v[i]   = 1'b0;
            hist_vec[i] = '0;
        end
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
